// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and types for the nibble-serial wide adder.
// Holds the nibble width, the FSM state encoding and the operand-width legality check.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operands are consumed whole nibbles at a time, and a single nibble is not worth serialising.
  function automatic bit width_ok(input int w);
    return ((w % NIB_W) == 0) && (w >= 2 * NIB_W);
  endfunction

endpackage

// File: rtl/rippleca.sv
// Existing 4-bit ripple-carry adder: purely combinational, carry ripples LSB to MSB.
module rippleca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c4
);

  logic [4:0] c;

  // NOTE: blocking assignments in always_comb, with every output given a default first, so no latch is inferred.
  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c4 = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per cycle through rippleca,
// carrying between nibbles in a register, with valid/ready on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e                      state;
  logic [IDX_W-1:0]            idx;
  logic                        carry;
  logic [NIB-1:0][NIB_W-1:0]   a_q;
  logic [NIB-1:0][NIB_W-1:0]   b_q;
  logic [NIB-1:0][NIB_W-1:0]   sum_q;

  logic [NIB_W-1:0]            nib_sum;
  logic                        nib_c4;

  rippleca u_nibble (
    .a   (a_q[idx]),
    .b   (b_q[idx]),
    .cin (carry),
    .sum (nib_sum),
    .c4  (nib_c4)
  );

  assign in_ready = (state == IDLE) && !rst;
  assign sum      = sum_q;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: the operand and sum registers are reset too, so an aborted operation leaves no stale nibbles or carry behind.
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum_q <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          sum_q[idx] <= nib_sum;
          carry      <= nib_c4;
          if (idx == LAST_IDX) begin
            cout      <= nib_c4;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          // Result stays on sum/cout after the handshake until the next capture.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
